user_ip_apb_bridge: RTL and testbench
=====================================

// Module: user_ip_apb_bridge
// PURPOSE
//  Native-bus (picorv32 mem_valid/mem_ready) to APB4 bridge feeding the user IP slots.
//  Decodes the slot index from the address and runs one APB4 SETUP/ACCESS transfer per request.
//  Returns read data and ready to the CPU side. A watchdog aborts hung transfers.
//  Sits between the SoC interconnect and the user_ip_design instances (one psel per slot).
// PARAMETERS
//  SLOT_NUM  4    number of user IP slots; power of two, >=2
//  SLOT_AW   8    byte-address bits per slot window (256 B); slot = addr[SLOT_AW +: $clog2(SLOT_NUM)]
//  TIMEOUT   255  max ACCESS cycles before abort; 0 disables the watchdog
// PORTS
//  clk_i          in   1            system clock
//  rst_n_i        in   1            async active-low reset
//  mem_valid_i    in   1            request valid; held until mem_ready_o
//  mem_addr_i     in   32           byte address
//  mem_wdata_i    in   32           write data
//  mem_wstrb_i    in   4            byte strobes; 0 = read
//  mem_ready_o    out  1            1-cycle completion pulse
//  mem_rdata_o    out  32           read data, valid when mem_ready_o=1
//  apb_paddr_o    out  32           {'0, addr[SLOT_AW-1:0]} (slot-local offset)
//  apb_psel_o     out  SLOT_NUM     one-hot slot select
//  apb_penable_o  out  1            APB enable
//  apb_pwrite_o   out  1            APB write
//  apb_pwdata_o   out  32           APB write data
//  apb_pstrb_o    out  4            APB strobes (0 on reads)
//  apb_pprot_o    out  3            fixed 3'b000
//  apb_pready_i   in   SLOT_NUM     per-slot pready
//  apb_prdata_i   in   32*SLOT_NUM  per-slot prdata, slot k at [32k +: 32]
//  apb_pslverr_i  in   SLOT_NUM     per-slot pslverr
//  err_clr_i      in   1            clears err_o (sync, 1-cycle pulse)
//  err_o          out  1            sticky: pslverr or timeout seen
// BEHAVIOUR
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs reset to 0; state resets to IDLE.
//  IDLE: on mem_valid_i, register addr/wdata/wstrb/slot; pwrite=|wstrb; go SETUP.
//  SETUP: psel[slot]=1, penable=0, all APB outputs stable; go ACCESS next cycle.
//  ACCESS: psel[slot]=1, penable=1. The watchdog counter starts at 0 and increments each ACCESS cycle.
//   pready[slot]=1: latch rdata = pslverr ? 0 : prdata[slot] (reads only; writes return 0);
//    set err_o if pslverr; go RESP.
//   No pready and count==TIMEOUT-1 (TIMEOUT!=0): abort. psel/penable drop next cycle, rdata=0, err_o=1, go RESP.
//  RESP: psel=0, penable=0, mem_ready_o=1 for exactly this cycle; go IDLE. No new request is accepted in RESP.
//  Only pready/prdata/pslverr of the selected slot are observed; other slots are ignored.
//  Latency: zero-wait read gives mem_ready_o 3 cycles after mem_valid_i is sampled. Each pready wait adds 1 cycle.
//  Back-to-back: a request held high in IDLE after RESP starts the next transfer (1 idle cycle minimum).
//  mem_valid_i dropping mid-transfer is ignored; the transfer completes and mem_ready_o still pulses.
//  Address/data changes after capture are ignored until the next IDLE.
//  err_o: set has priority over a same-cycle err_clr_i. It remains set until cleared.
//  Reset mid-transfer: outputs go to 0 immediately (async); the counter and latched request are cleared.
//  Counter width $clog2(TIMEOUT+1); it never wraps (abort occurs first).
// TESTING
//  Read addr 0x0000_0200 (slot 2, SLOT_AW=8), slot2 pready=1, prdata=0xA5A5_0001
//   -> psel=4'b0100, paddr=0x00; mem_ready_o 3 cycles later; rdata=0xA5A5_0001; err_o=0.
//  Write 0x0000_0104 wdata=0x1234_5678 wstrb=4'hF, slot1 pready low 3 cycles
//   -> pwrite=1, paddr=0x04, pstrb=4'hF held 5 cycles (SETUP+4 ACCESS); mem_ready_o after 6 cycles.
//  Read slot 3 with pready=1, pslverr=1, prdata=0xFFFF_FFFF
//   -> mem_rdata_o=0, err_o=1; err_clr_i pulse -> err_o=0 next cycle.
//  TIMEOUT=4, slot 0 pready stuck low
//   -> penable high exactly 4 cycles; mem_ready_o pulses; rdata=0; err_o=1.
//  Two back-to-back reads to slot 0 then slot 1
//   -> psel 0001 then 0010, never overlapping; two single-cycle mem_ready_o pulses.
//  rst_n_i low during ACCESS
//   -> psel/penable/mem_ready_o=0 at once; after release, the FSM is in IDLE and the next request works normally.

Source files
------------

// File: rtl/user_ip_apb_bridge_if.sv
// rtl/user_ip_apb_bridge_if.sv - CPU native-bus and APB4 slot signals of the user IP bridge
// slave is the bridge's view; master is the view of the CPU side plus the slot devices.
interface user_ip_apb_bridge_if #(
  parameter int SLOT_NUM = 4
);
  logic                   mem_valid_i;
  logic [31:0]            mem_addr_i;
  logic [31:0]            mem_wdata_i;
  logic [3:0]             mem_wstrb_i;
  logic                   mem_ready_o;
  logic [31:0]            mem_rdata_o;
  logic [31:0]            apb_paddr_o;
  logic [SLOT_NUM-1:0]    apb_psel_o;
  logic                   apb_penable_o;
  logic                   apb_pwrite_o;
  logic [31:0]            apb_pwdata_o;
  logic [3:0]             apb_pstrb_o;
  logic [2:0]             apb_pprot_o;
  logic [SLOT_NUM-1:0]    apb_pready_i;
  logic [32*SLOT_NUM-1:0] apb_prdata_i;
  logic [SLOT_NUM-1:0]    apb_pslverr_i;
  logic                   err_clr_i;
  logic                   err_o;

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    input  apb_pready_i, apb_prdata_i, apb_pslverr_i, err_clr_i,
    output mem_ready_o, mem_rdata_o,
    output apb_paddr_o, apb_psel_o, apb_penable_o, apb_pwrite_o,
    output apb_pwdata_o, apb_pstrb_o, apb_pprot_o, err_o
  );

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    output apb_pready_i, apb_prdata_i, apb_pslverr_i, err_clr_i,
    input  mem_ready_o, mem_rdata_o,
    input  apb_paddr_o, apb_psel_o, apb_penable_o, apb_pwrite_o,
    input  apb_pwdata_o, apb_pstrb_o, apb_pprot_o, err_o
  );
endinterface

// File: rtl/user_ip_apb_bridge.sv
// rtl/user_ip_apb_bridge.sv - picorv32 native bus to APB4 bridge for the user IP slots
// One SETUP/ACCESS transfer per request, slot decoded from the address, watchdog on ACCESS.
module user_ip_apb_bridge #(
  parameter int SLOT_NUM = 4,
  parameter int SLOT_AW  = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  user_ip_apb_bridge_if.slave  bus
);
  localparam int SW = $clog2(SLOT_NUM);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit WDOG_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SLOT_AW-1:0]  r_addr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [SW-1:0]       r_slot;
  logic [CW-1:0]       r_cnt;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic [SLOT_NUM-1:0] w_psel;
  logic                w_penable;
  logic                w_ready;
  logic                w_load;
  logic                w_pready;
  logic                w_pslverr;
  logic [31:0]         w_prdata;
  logic                w_cnt_last;
  logic                w_done;
  logic                w_abort;
  logic                w_err_set;
  logic                w_unused_addr;

  assign w_load     = (r_state == ST_IDLE) && bus.mem_valid_i;
  assign w_pready   = bus.apb_pready_i[r_slot];
  assign w_pslverr  = bus.apb_pslverr_i[r_slot];
  assign w_prdata   = bus.apb_prdata_i[{r_slot, 5'b0} +: 32];
  assign w_cnt_last = WDOG_EN && (r_cnt == CNT_LAST);
  assign w_done     = (r_state == ST_ACCESS) && w_pready;
  assign w_abort    = (r_state == ST_ACCESS) && !w_pready && w_cnt_last;
  assign w_err_set  = (w_done && w_pslverr) || w_abort;
  assign w_unused_addr = ^bus.mem_addr_i[31:SLOT_AW+SW];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_psel      = '0;
    w_penable   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_valid_i) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_psel[r_slot] = 1'b1;
        w_state_nxt    = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel[r_slot] = 1'b1;
        w_penable      = 1'b1;
        if (w_done || w_abort) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_ready     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_slot  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_addr  <= bus.mem_addr_i[SLOT_AW-1:0];
        r_wdata <= bus.mem_wdata_i;
        r_wstrb <= bus.mem_wstrb_i;
        r_slot  <= bus.mem_addr_i[SLOT_AW +: SW];
        r_rdata <= '0;
      end
      // Counter only advances while waiting, so it stops at CNT_LAST and cannot wrap.
      if (r_state == ST_SETUP) begin
        r_cnt <= '0;
      end else if (WDOG_EN && (r_state == ST_ACCESS) && !w_pready && !w_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_rdata <= ((|r_wstrb) || w_pslverr) ? 32'h0 : w_prdata;
      end else if (w_abort) begin
        r_rdata <= '0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (bus.err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.mem_ready_o   = w_ready;
  assign bus.mem_rdata_o   = r_rdata;
  assign bus.apb_paddr_o   = {{(32-SLOT_AW){1'b0}}, r_addr};
  assign bus.apb_psel_o    = w_psel;
  assign bus.apb_penable_o = w_penable;
  assign bus.apb_pwrite_o  = |r_wstrb;
  assign bus.apb_pwdata_o  = r_wdata;
  assign bus.apb_pstrb_o   = r_wstrb;
  assign bus.apb_pprot_o   = 3'b000;
  assign bus.err_o         = r_err;
endmodule

// File: tb/tb_user_ip_apb_bridge.sv
// tb/tb_user_ip_apb_bridge.sv - directed self-checking bench for user_ip_apb_bridge
module tb_user_ip_apb_bridge;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  user_ip_apb_bridge_if #(.SLOT_NUM(4)) bus ();

  user_ip_apb_bridge #(.SLOT_NUM(4), .SLOT_AW(8), .TIMEOUT(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.mem_valid_i   = 1'b0;
    bus.mem_addr_i    = 32'h0;
    bus.mem_wdata_i   = 32'h0;
    bus.mem_wstrb_i   = 4'h0;
    bus.apb_pready_i  = 4'h0;
    bus.apb_prdata_i  = '0;
    bus.apb_pslverr_i = 4'h0;
    bus.err_clr_i     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_total++; if (bus.apb_psel_o !== 4'b0000) $display("FAIL rst_psel got %b exp 0000", bus.apb_psel_o); else n_pass++;
    n_total++; if (bus.apb_penable_o !== 1'b0) $display("FAIL rst_penable got %b exp 0", bus.apb_penable_o); else n_pass++;
    n_total++; if (bus.mem_ready_o !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.mem_ready_o); else n_pass++;
    n_total++; if (bus.err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.err_o); else n_pass++;
    n_total++; if (bus.apb_paddr_o !== 32'h0) $display("FAIL rst_paddr got %h exp 0", bus.apb_paddr_o); else n_pass++;
    n_total++; if (bus.mem_rdata_o !== 32'h0) $display("FAIL rst_rdata got %h exp 0", bus.mem_rdata_o); else n_pass++;
    n_total++; if (bus.apb_pprot_o !== 3'b000) $display("FAIL rst_pprot got %b exp 000", bus.apb_pprot_o); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read;
    bus.apb_pready_i = 4'b0100;
    bus.apb_prdata_i = {32'h3333_3333, 32'hA5A5_0001, 32'h1111_1111, 32'h0000_0BAD};
    bus.mem_addr_i   = 32'h0000_0200;
    bus.mem_wstrb_i  = 4'h0;
    bus.mem_valid_i  = 1'b1;
    tick();
    n_total++; if (bus.apb_psel_o !== 4'b0100) $display("FAIL rd_setup_psel got %b exp 0100", bus.apb_psel_o); else n_pass++;
    n_total++; if (bus.apb_penable_o !== 1'b0) $display("FAIL rd_setup_penable got %b exp 0", bus.apb_penable_o); else n_pass++;
    n_total++; if (bus.apb_paddr_o !== 32'h0) $display("FAIL rd_paddr got %h exp 0", bus.apb_paddr_o); else n_pass++;
    n_total++; if (bus.apb_pwrite_o !== 1'b0) $display("FAIL rd_pwrite got %b exp 0", bus.apb_pwrite_o); else n_pass++;
    n_total++; if (bus.mem_ready_o !== 1'b0) $display("FAIL rd_early_ready1 got %b exp 0", bus.mem_ready_o); else n_pass++;
    tick();
    n_total++; if (bus.apb_penable_o !== 1'b1) $display("FAIL rd_access_penable got %b exp 1", bus.apb_penable_o); else n_pass++;
    n_total++; if (bus.mem_ready_o !== 1'b0) $display("FAIL rd_early_ready2 got %b exp 0", bus.mem_ready_o); else n_pass++;
    tick();
    n_total++; if (bus.mem_ready_o !== 1'b1) $display("FAIL rd_ready got %b exp 1", bus.mem_ready_o); else n_pass++;
    n_total++; if (bus.mem_rdata_o !== 32'hA5A5_0001) $display("FAIL rd_rdata got %h exp a5a50001", bus.mem_rdata_o); else n_pass++;
    n_total++; if (bus.apb_psel_o !== 4'b0000) $display("FAIL rd_resp_psel got %b exp 0000", bus.apb_psel_o); else n_pass++;
    n_total++; if (bus.err_o !== 1'b0) $display("FAIL rd_err got %b exp 0", bus.err_o); else n_pass++;
    bus.mem_valid_i = 1'b0;
    tick();
    n_total++; if (bus.mem_ready_o !== 1'b0) $display("FAIL rd_ready_pulse got %b exp 0", bus.mem_ready_o); else n_pass++;
  endtask

  task automatic test_write;
    idle_inputs();
    bus.apb_prdata_i = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0};
    bus.mem_addr_i   = 32'h0000_0104;
    bus.mem_wdata_i  = 32'h1234_5678;
    bus.mem_wstrb_i  = 4'hF;
    bus.mem_valid_i  = 1'b1;
    tick();
    n_total++; if (bus.apb_psel_o !== 4'b0010) $display("FAIL wr_setup_psel got %b exp 0010", bus.apb_psel_o); else n_pass++;
    n_total++; if (bus.apb_pwrite_o !== 1'b1) $display("FAIL wr_pwrite got %b exp 1", bus.apb_pwrite_o); else n_pass++;
    n_total++; if (bus.apb_pwdata_o !== 32'h1234_5678) $display("FAIL wr_pwdata got %h exp 12345678", bus.apb_pwdata_o); else n_pass++;
    // Request drops and the address moves mid-transfer; the captured transfer must continue.
    bus.mem_valid_i = 1'b0;
    bus.mem_addr_i  = 32'h0000_0308;
    bus.mem_wstrb_i = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (bus.apb_penable_o !== 1'b1) $display("FAIL wr_penable_%0d got %b exp 1", i, bus.apb_penable_o); else n_pass++;
      n_total++; if (bus.apb_paddr_o !== 32'h4 || bus.apb_pstrb_o !== 4'hF || bus.apb_psel_o !== 4'b0010)
        $display("FAIL wr_hold_%0d got paddr %h pstrb %h psel %b exp 4 f 0010", i, bus.apb_paddr_o, bus.apb_pstrb_o, bus.apb_psel_o);
      else n_pass++;
      n_total++; if (bus.mem_ready_o !== 1'b0) $display("FAIL wr_early_ready_%0d got %b exp 0", i, bus.mem_ready_o); else n_pass++;
      if (i == 3) bus.apb_pready_i = 4'b0010;
    end
    tick();
    n_total++; if (bus.mem_ready_o !== 1'b1) $display("FAIL wr_ready got %b exp 1", bus.mem_ready_o); else n_pass++;
    n_total++; if (bus.mem_rdata_o !== 32'h0) $display("FAIL wr_rdata got %h exp 0", bus.mem_rdata_o); else n_pass++;
    n_total++; if (bus.err_o !== 1'b0) $display("FAIL wr_err got %b exp 0", bus.err_o); else n_pass++;
    tick();
    n_total++; if (bus.mem_ready_o !== 1'b0 || bus.apb_psel_o !== 4'b0000)
      $display("FAIL wr_idle got ready %b psel %b exp 0 0000", bus.mem_ready_o, bus.apb_psel_o);
    else n_pass++;
  endtask

  task automatic test_slverr;
    idle_inputs();
    bus.apb_pready_i  = 4'b1000;
    bus.apb_pslverr_i = 4'b1000;
    bus.apb_prdata_i  = {32'hFFFF_FFFF, 32'h2222_2222, 32'h1111_1111, 32'h0};
    bus.mem_addr_i    = 32'h0000_0300;
    bus.mem_valid_i   = 1'b1;
    tick();
    tick();
    tick();
    n_total++; if (bus.mem_ready_o !== 1'b1) $display("FAIL se_ready got %b exp 1", bus.mem_ready_o); else n_pass++;
    n_total++; if (bus.mem_rdata_o !== 32'h0) $display("FAIL se_rdata got %h exp 0", bus.mem_rdata_o); else n_pass++;
    n_total++; if (bus.err_o !== 1'b1) $display("FAIL se_err got %b exp 1", bus.err_o); else n_pass++;
    bus.mem_valid_i = 1'b0;
    tick();
    n_total++; if (bus.err_o !== 1'b1) $display("FAIL se_sticky got %b exp 1", bus.err_o); else n_pass++;
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    n_total++; if (bus.err_o !== 1'b0) $display("FAIL se_clr got %b exp 0", bus.err_o); else n_pass++;
  endtask

  task automatic test_timeout;
    idle_inputs();
    bus.apb_pready_i  = 4'b0010;
    bus.apb_pslverr_i = 4'b0010;
    bus.apb_prdata_i  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    bus.mem_addr_i    = 32'h0000_0010;
    bus.mem_valid_i   = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (bus.apb_penable_o !== 1'b1 || bus.apb_psel_o !== 4'b0001)
        $display("FAIL to_access_%0d got penable %b psel %b exp 1 0001", i, bus.apb_penable_o, bus.apb_psel_o);
      else n_pass++;
      n_total++; if (bus.err_o !== 1'b0) $display("FAIL to_err_early_%0d got %b exp 0", i, bus.err_o); else n_pass++;
      if (i == 3) bus.err_clr_i = 1'b1;
    end
    tick();
    n_total++; if (bus.apb_penable_o !== 1'b0 || bus.apb_psel_o !== 4'b0000)
      $display("FAIL to_drop got penable %b psel %b exp 0 0000", bus.apb_penable_o, bus.apb_psel_o);
    else n_pass++;
    n_total++; if (bus.mem_ready_o !== 1'b1) $display("FAIL to_ready got %b exp 1", bus.mem_ready_o); else n_pass++;
    n_total++; if (bus.mem_rdata_o !== 32'h0) $display("FAIL to_rdata got %h exp 0", bus.mem_rdata_o); else n_pass++;
    n_total++; if (bus.err_o !== 1'b1) $display("FAIL to_err_set_over_clr got %b exp 1", bus.err_o); else n_pass++;
    tick();
    bus.err_clr_i = 1'b0;
    n_total++; if (bus.err_o !== 1'b0) $display("FAIL to_err_clr got %b exp 0", bus.err_o); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_psel [0:7];
    logic       exp_rdy  [0:7];
    int         n_ready;
    exp_psel = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    exp_rdy  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_ready  = 0;
    idle_inputs();
    bus.apb_pready_i = 4'b1111;
    bus.apb_prdata_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.mem_addr_i   = 32'h0000_0000;
    bus.mem_valid_i  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_total++; if (bus.apb_psel_o !== exp_psel[c] || bus.mem_ready_o !== exp_rdy[c])
        $display("FAIL b2b_cyc%0d got psel %b ready %b exp %b %b", c, bus.apb_psel_o, bus.mem_ready_o, exp_psel[c], exp_rdy[c]);
      else n_pass++;
      if (bus.mem_ready_o === 1'b1) begin
        n_total++;
        if (bus.mem_rdata_o !== ((n_ready == 0) ? 32'h1111_1111 : 32'h2222_2222))
          $display("FAIL b2b_rdata%0d got %h", n_ready, bus.mem_rdata_o);
        else n_pass++;
        n_ready++;
        if (n_ready == 1) bus.mem_addr_i = 32'h0000_0100;
        else bus.mem_valid_i = 1'b0;
      end
    end
    n_total++; if (n_ready !== 2) $display("FAIL b2b_pulses got %0d exp 2", n_ready); else n_pass++;
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    bus.mem_addr_i  = 32'h0000_0200;
    bus.mem_valid_i = 1'b1;
    tick();
    tick();
    n_total++; if (bus.apb_penable_o !== 1'b1) $display("FAIL rm_in_access got %b exp 1", bus.apb_penable_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.apb_psel_o !== 4'b0000 || bus.apb_penable_o !== 1'b0 || bus.mem_ready_o !== 1'b0)
      $display("FAIL rm_async got psel %b penable %b ready %b exp 0000 0 0", bus.apb_psel_o, bus.apb_penable_o, bus.mem_ready_o);
    else n_pass++;
    bus.mem_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (bus.apb_psel_o !== 4'b0000) $display("FAIL rm_idle got psel %b exp 0000", bus.apb_psel_o); else n_pass++;
    bus.apb_pready_i = 4'b0100;
    bus.apb_prdata_i = {32'h0, 32'h0BAD_F00D, 32'h0, 32'h0};
    bus.mem_valid_i  = 1'b1;
    tick();
    n_total++; if (bus.apb_psel_o !== 4'b0100 || bus.apb_penable_o !== 1'b0)
      $display("FAIL rm_setup got psel %b penable %b exp 0100 0", bus.apb_psel_o, bus.apb_penable_o);
    else n_pass++;
    tick();
    tick();
    n_total++; if (bus.mem_ready_o !== 1'b1 || bus.mem_rdata_o !== 32'h0BAD_F00D)
      $display("FAIL rm_read got ready %b rdata %h exp 1 0badf00d", bus.mem_ready_o, bus.mem_rdata_o);
    else n_pass++;
    bus.mem_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
